hn_sam_pipe: RTL and testbench

//  Registered, flow-controlled home-node system address map (SAM) stage.
//  - Rewrites each flit's tgt_id/src_id/id.sid from its cache id (id.cid). Supports sliced, hashed and centralised LLC.
//  - Physical slices are steered through a runtime-programmable remap table, so slices can be disabled or rebalanced.
//  - Sits between the HN protocol engine and the router local input port; emits flit_dec_t for router input decode.

---
 rtl/hn_sam_pipe_pkg.sv | 80 ++++++++
 rtl/hn_sam_pipe_if.sv | 24 ++
 rtl/hn_sam_pipe_skid_buf.sv | 70 +++++++
 rtl/hn_sam_pipe.sv | 165 ++++++++++++++++
 tb/tb_hn_sam_pipe.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hn_sam_pipe_pkg.sv
// hn_sam_pipe_pkg: shared types, sizes and helpers for the home-node SAM stage.
// Optional build macro: USE_QOS_VALUE adds qos_value to the flit and to the decoded header.
package hn_sam_pipe_pkg;

  localparam int NODE_NUM_X_DIMESION      = 2;
  localparam int NODE_NUM_Y_DIMESION      = 2;
  localparam int NodeID_X_Width           = 2;
  localparam int NodeID_Y_Width           = 2;
  localparam int NodeID_Device_Port_Width = 2;
  localparam int NodeID_Device_Id_Width   = 2;
  localparam int NodeIdWidth = NodeID_X_Width + NodeID_Y_Width +
                               NodeID_Device_Port_Width + NodeID_Device_Id_Width;
  localparam int CidWidth    = 8;
  localparam int SidWidth    = 8;
  localparam int QosWidth    = 4;
  localparam int IoPortWidth = 3;

`ifdef USE_QOS_VALUE
  localparam int FlitDataWidth = 256 - 2 * NodeIdWidth - CidWidth - SidWidth - QosWidth;
`else
  localparam int FlitDataWidth = 256 - 2 * NodeIdWidth - CidWidth - SidWidth;
`endif

  typedef enum logic [1:0] {
    SAM_SLICED  = 2'd0,
    SAM_CENTRAL = 2'd1,
    SAM_HASHED  = 2'd2
  } sam_mode_e;

  typedef logic [IoPortWidth-1:0] io_port_t;

  typedef struct packed {
    logic [NodeID_X_Width-1:0]           x_position;
    logic [NodeID_Y_Width-1:0]           y_position;
    logic [NodeID_Device_Port_Width-1:0] device_port;
    logic [NodeID_Device_Id_Width-1:0]   device_id;
  } node_id_t;

  typedef struct packed {
    logic [CidWidth-1:0] cid;
    logic [SidWidth-1:0] sid;
  } flit_id_t;

  typedef struct packed {
    node_id_t                 tgt_id;
    node_id_t                 src_id;
    flit_id_t                 id;
`ifdef USE_QOS_VALUE
    logic [QosWidth-1:0]      qos_value;
`endif
    logic [FlitDataWidth-1:0] data;
  } flit_payload_t;

  typedef struct packed {
    node_id_t            tgt_id;
    node_id_t            src_id;
    io_port_t            look_ahead_routing;
`ifdef USE_QOS_VALUE
    logic [QosWidth-1:0] qos_value;
`endif
  } flit_dec_t;

  // Width of a slice index; a single slice still needs one bit.
  function automatic int slice_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // XOR-fold the cache id into w-bit chunks (result lands in the low w bits).
  function automatic logic [CidWidth-1:0] cid_fold(input logic [CidWidth-1:0] cid, input int w);
    logic [CidWidth-1:0] mask;
    logic [CidWidth-1:0] fold;
    mask = (CidWidth'(1) << w) - CidWidth'(1);
    fold = '0;
    for (int c = 0; c < CidWidth; c += w) begin
      fold = fold ^ ((cid >> c) & mask);
    end
    return fold;
  endfunction

endpackage

// File: rtl/hn_sam_pipe_if.sv
// hn_sam_pipe_if: flit handshake bundle for the SAM stage.
// master = upstream/downstream environment, slave = the SAM stage itself.
interface hn_sam_pipe_if;
  import hn_sam_pipe_pkg::*;

  logic          flit_v_i;
  logic          flit_rdy_o;
  flit_payload_t flit_i;
  io_port_t      flit_look_ahead_routing_i;
  logic          flit_v_o;
  logic          flit_rdy_i;
  flit_payload_t flit_o;
  flit_dec_t     flit_dec_o;

  modport master (
    output flit_v_i, flit_i, flit_look_ahead_routing_i, flit_rdy_i,
    input  flit_rdy_o, flit_v_o, flit_o, flit_dec_o
  );

  modport slave (
    input  flit_v_i, flit_i, flit_look_ahead_routing_i, flit_rdy_i,
    output flit_rdy_o, flit_v_o, flit_o, flit_dec_o
  );
endinterface

// File: rtl/hn_sam_pipe_skid_buf.sv
// hn_sam_skid_buf: 2-entry valid/ready skid buffer (output register + skid register).
// in_rdy_o depends only on the skid flop, so there is no combinational path from out_rdy_i.
module hn_sam_skid_buf #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic in_v_i,
  output logic in_rdy_o,
  input  T     in_data_i,
  output logic out_v_o,
  input  logic out_rdy_i,
  output T     out_data_o
);

  logic out_v_q, out_v_d;
  logic skid_v_q, skid_v_d;
  T     out_data_q, out_data_d;
  T     skid_data_q, skid_data_d;
  logic in_fire_s, out_free_s;

  // Next-state: refill the output slot from skid first, else from the input; park input in skid when stalled.
  always_comb begin
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    in_fire_s   = in_v_i & ~skid_v_q;
    out_free_s  = ~out_v_q | out_rdy_i;
    if (out_free_s) begin
      if (skid_v_q) begin
        out_v_d    = 1'b1;
        out_data_d = skid_data_q;
        skid_v_d   = 1'b0;
      end else if (in_fire_s) begin
        out_v_d    = 1'b1;
        out_data_d = in_data_i;
      end else begin
        out_v_d    = 1'b0;
      end
    end else begin
      if (in_fire_s) begin
        skid_v_d    = 1'b1;
        skid_data_d = in_data_i;
      end else begin
        skid_v_d    = skid_v_q;
      end
    end
  end

  // State registers; reset empties both entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v_q     <= 1'b0;
      skid_v_q    <= 1'b0;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else begin
      out_v_q     <= out_v_d;
      skid_v_q    <= skid_v_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_rdy_o   = ~skid_v_q;
  assign out_v_o    = out_v_q;
  assign out_data_o = out_data_q;

endmodule

// File: rtl/hn_sam_pipe.sv
// hn_sam_pipe: registered home-node system-address-map stage.
// Rewrites tgt_id/src_id/id.sid from id.cid (sliced, hashed or central LLC) through a
// programmable logical->physical slice remap table, then buffers in a 2-entry skid buffer.
// Optional build macro: HN_SAM_PERF_CNT_EN enables per-physical-slice 16-bit transfer counters.
module hn_sam_pipe
  import hn_sam_pipe_pkg::*;
#(
  parameter int        SLICE_NUM = 4,
  parameter sam_mode_e SAM_MODE  = SAM_SLICED,
  parameter int        CENTRAL_X = 1,
  parameter int        CENTRAL_Y = 0,
  localparam int       SliceIdxW = slice_idx_w(SLICE_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NodeID_X_Width-1:0] node_id_x_i,
  input  logic [NodeID_Y_Width-1:0] node_id_y_i,
  hn_sam_pipe_if.slave              bus,
  input  logic                      cfg_we_i,
  input  logic [SliceIdxW-1:0]      cfg_idx_i,
  input  logic [SliceIdxW-1:0]      cfg_slice_i,
  input  logic                      perf_clr_i,
  output logic [SLICE_NUM*16-1:0]   perf_cnt_o
);

  localparam int CentralSlice = (CENTRAL_Y * NODE_NUM_X_DIMESION + CENTRAL_X) % SLICE_NUM;

  typedef struct packed {
    flit_payload_t        flit;
    flit_dec_t            dec;
    logic [SliceIdxW-1:0] slice;
  } entry_t;

  logic [SliceIdxW-1:0]      remap_q [SLICE_NUM];
  logic [SliceIdxW-1:0]      remap_d [SLICE_NUM];
  logic [SliceIdxW-1:0]      lidx_s, phys_s;
  logic [NodeID_X_Width-1:0] tgt_x_s;
  logic [NodeID_Y_Width-1:0] tgt_y_s;
  entry_t                    in_entry_s, out_entry_s;
  logic                      out_v_s;

  // Remap table update; out-of-range logical indices are dropped.
  always_comb begin
    remap_d = remap_q;
    if (cfg_we_i && (int'(cfg_idx_i) < SLICE_NUM)) begin
      remap_d[cfg_idx_i] = cfg_slice_i;
    end else begin
      remap_d = remap_q;
    end
  end

  // Remap table registers; reset restores the identity map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLICE_NUM; i++) begin
        remap_q[i] <= SliceIdxW'(i);
      end
    end else begin
      remap_q <= remap_d;
    end
  end

  // Target selection at accept time; uses the remap entry as it stands before this edge.
  always_comb begin
    case (SAM_MODE)
      SAM_SLICED: lidx_s = SliceIdxW'(int'(bus.flit_i.id.cid) % SLICE_NUM);
      SAM_HASHED: lidx_s = SliceIdxW'(int'(cid_fold(bus.flit_i.id.cid, SliceIdxW)) % SLICE_NUM);
      default:    lidx_s = '0;
    endcase
    if (SAM_MODE == SAM_CENTRAL) begin
      phys_s  = SliceIdxW'(CentralSlice);
      tgt_x_s = NodeID_X_Width'(CENTRAL_X);
      tgt_y_s = NodeID_Y_Width'(CENTRAL_Y);
    end else begin
      phys_s  = remap_q[lidx_s];
      tgt_x_s = NodeID_X_Width'(int'(phys_s) % NODE_NUM_X_DIMESION);
      tgt_y_s = NodeID_Y_Width'(int'(phys_s) / NODE_NUM_X_DIMESION);
    end
  end

  // Header rewrite and decode bundle; everything not named here passes through.
  always_comb begin
    in_entry_s                         = '0;
    in_entry_s.flit                    = bus.flit_i;
    in_entry_s.flit.tgt_id.x_position  = tgt_x_s;
    in_entry_s.flit.tgt_id.y_position  = tgt_y_s;
    in_entry_s.flit.tgt_id.device_port = '0;
    in_entry_s.flit.tgt_id.device_id   = '0;
    in_entry_s.flit.src_id.x_position  = node_id_x_i;
    in_entry_s.flit.src_id.y_position  = node_id_y_i;
    in_entry_s.flit.src_id.device_port = '0;
    in_entry_s.flit.src_id.device_id   = '0;
    in_entry_s.flit.id.sid = SidWidth'(int'(node_id_y_i) * NODE_NUM_X_DIMESION + int'(node_id_x_i));
    in_entry_s.dec.tgt_id              = in_entry_s.flit.tgt_id;
    in_entry_s.dec.src_id              = in_entry_s.flit.src_id;
    in_entry_s.dec.look_ahead_routing  = bus.flit_look_ahead_routing_i;
`ifdef USE_QOS_VALUE
    in_entry_s.dec.qos_value           = bus.flit_i.qos_value;
`endif
    in_entry_s.slice                   = phys_s;
  end

  hn_sam_skid_buf #(
    .T (entry_t)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_v_i     (bus.flit_v_i),
    .in_rdy_o   (bus.flit_rdy_o),
    .in_data_i  (in_entry_s),
    .out_v_o    (out_v_s),
    .out_rdy_i  (bus.flit_rdy_i),
    .out_data_o (out_entry_s)
  );

  assign bus.flit_v_o   = out_v_s;
  assign bus.flit_o     = out_entry_s.flit;
  assign bus.flit_dec_o = out_entry_s.dec;

`ifdef HN_SAM_PERF_CNT_EN
  logic [15:0] cnt_q [SLICE_NUM];
  logic [15:0] cnt_d [SLICE_NUM];
  logic        out_fire_s;

  // Count output transfers per physical slice, saturating; clear beats a same-cycle increment.
  always_comb begin
    cnt_d      = cnt_q;
    out_fire_s = out_v_s & bus.flit_rdy_i;
    if (perf_clr_i) begin
      for (int i = 0; i < SLICE_NUM; i++) begin
        cnt_d[i] = 16'h0000;
      end
    end else if (out_fire_s && (int'(out_entry_s.slice) < SLICE_NUM) &&
                 (cnt_q[out_entry_s.slice] != 16'hFFFF)) begin
      cnt_d[out_entry_s.slice] = cnt_q[out_entry_s.slice] + 16'h0001;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLICE_NUM; i++) begin
        cnt_q[i] <= 16'h0000;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flatten counters onto the output bus (slice i at bits [16*i +: 16]).
  always_comb begin
    perf_cnt_o = '0;
    for (int i = 0; i < SLICE_NUM; i++) begin
      perf_cnt_o[i*16 +: 16] = cnt_q[i];
    end
  end
`else
  logic perf_unused_s;
  assign perf_unused_s = ^{perf_clr_i, out_entry_s.slice};
  assign perf_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_hn_sam_pipe.sv
// tb_hn_sam_pipe: directed bench for hn_sam_pipe. Three instances (sliced, central, hashed)
// run in lock-step on the same stimulus; expected targets are hand-computed per vector.
module tb_hn_sam_pipe;
  import hn_sam_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NodeID_X_Width-1:0] node_x = 2'd1;
  logic [NodeID_Y_Width-1:0] node_y = 2'd0;
  logic          in_v = 1'b0;
  flit_payload_t in_flit = '0;
  io_port_t      in_la = '0;
  logic          out_rdy = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_idx = 2'd0;
  logic [1:0]    cfg_slice = 2'd0;
  logic          perf_clr = 1'b0;
  logic [63:0]   perf_sl, perf_ce, perf_ha;

  int n_checks = 0;
  int n_fail   = 0;

  hn_sam_pipe_if if_sl ();
  hn_sam_pipe_if if_ce ();
  hn_sam_pipe_if if_ha ();

  assign if_sl.flit_v_i = in_v;  assign if_sl.flit_i = in_flit;
  assign if_ce.flit_v_i = in_v;  assign if_ce.flit_i = in_flit;
  assign if_ha.flit_v_i = in_v;  assign if_ha.flit_i = in_flit;
  assign if_sl.flit_look_ahead_routing_i = in_la;
  assign if_ce.flit_look_ahead_routing_i = in_la;
  assign if_ha.flit_look_ahead_routing_i = in_la;
  assign if_sl.flit_rdy_i = out_rdy;
  assign if_ce.flit_rdy_i = out_rdy;
  assign if_ha.flit_rdy_i = out_rdy;

  logic          v_o   [3];
  logic          rdy_o [3];
  flit_payload_t f_o   [3];
  flit_dec_t     d_o   [3];
  assign v_o[0] = if_sl.flit_v_o; assign rdy_o[0] = if_sl.flit_rdy_o;
  assign v_o[1] = if_ce.flit_v_o; assign rdy_o[1] = if_ce.flit_rdy_o;
  assign v_o[2] = if_ha.flit_v_o; assign rdy_o[2] = if_ha.flit_rdy_o;
  assign f_o[0] = if_sl.flit_o;   assign d_o[0] = if_sl.flit_dec_o;
  assign f_o[1] = if_ce.flit_o;   assign d_o[1] = if_ce.flit_dec_o;
  assign f_o[2] = if_ha.flit_o;   assign d_o[2] = if_ha.flit_dec_o;

  hn_sam_pipe #(.SAM_MODE(SAM_SLICED)) u_sl (
    .clk(clk), .rst(rst), .node_id_x_i(node_x), .node_id_y_i(node_y), .bus(if_sl),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_slice_i(cfg_slice),
    .perf_clr_i(perf_clr), .perf_cnt_o(perf_sl)
  );
  hn_sam_pipe #(.SAM_MODE(SAM_CENTRAL), .CENTRAL_X(1), .CENTRAL_Y(0)) u_ce (
    .clk(clk), .rst(rst), .node_id_x_i(node_x), .node_id_y_i(node_y), .bus(if_ce),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_slice_i(cfg_slice),
    .perf_clr_i(perf_clr), .perf_cnt_o(perf_ce)
  );
  hn_sam_pipe #(.SAM_MODE(SAM_HASHED)) u_ha (
    .clk(clk), .rst(rst), .node_id_x_i(node_x), .node_id_y_i(node_y), .bus(if_ha),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_slice_i(cfg_slice),
    .perf_clr_i(perf_clr), .perf_cnt_o(perf_ha)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic flit_payload_t mk_flit(input logic [7:0] cid, input logic [15:0] seq);
    flit_payload_t f;
    f = '0;
    f.tgt_id     = node_id_t'(8'hFF);
    f.src_id     = node_id_t'(8'hEE);
    f.id.cid     = cid;
    f.id.sid     = 8'hAA;
    f.data[15:0] = seq;
    f.data[31:16] = 16'h5A5A;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] cid, input logic [15:0] seq);
    in_v    = v;
    in_flit = mk_flit(cid, seq);
    in_la   = io_port_t'(seq[2:0]);
  endtask

  // Full header/payload check of one instance's output against hand-computed values.
  task automatic expect_out(input int k, input string tag, input logic [7:0] cid,
                            input logic [15:0] seq, input logic [1:0] tx, input logic [1:0] ty);
    flit_payload_t ef;
    logic [7:0]    etgt;
    ef   = mk_flit(cid, seq);
    etgt = {tx, ty, 4'b0000};
    check_eq($sformatf("%s_i%0d_v", tag, k), 64'(v_o[k]), 64'd1);
    check_eq($sformatf("%s_i%0d_tgt", tag, k), 64'(f_o[k].tgt_id), 64'(etgt));
    check_eq($sformatf("%s_i%0d_src", tag, k), 64'(f_o[k].src_id), 64'(8'h40));
    check_eq($sformatf("%s_i%0d_sid", tag, k), 64'(f_o[k].id.sid), 64'd1);
    check_eq($sformatf("%s_i%0d_cid", tag, k), 64'(f_o[k].id.cid), 64'(cid));
    check_eq($sformatf("%s_i%0d_data", tag, k), f_o[k].data[63:0], ef.data[63:0]);
    check_eq($sformatf("%s_i%0d_dtgt", tag, k), 64'(d_o[k].tgt_id), 64'(etgt));
    check_eq($sformatf("%s_i%0d_dsrc", tag, k), 64'(d_o[k].src_id), 64'(8'h40));
    check_eq($sformatf("%s_i%0d_dla", tag, k), 64'(d_o[k].look_ahead_routing), 64'(seq[2:0]));
  endtask

  // Sliced expectation (sx,sy), central always (1,0), hashed expectation (hx,hy).
  task automatic expect_all(input string tag, input logic [7:0] cid, input logic [15:0] seq,
                            input logic [1:0] sx, input logic [1:0] sy,
                            input logic [1:0] hx, input logic [1:0] hy);
    expect_out(0, tag, cid, seq, sx, sy);
    expect_out(1, tag, cid, seq, 2'd1, 2'd0);
    expect_out(2, tag, cid, seq, hx, hy);
  endtask

  task automatic expect_seq_all(input string tag, input logic v, input logic [15:0] seq);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_i%0d_v", tag, k), 64'(v_o[k]), 64'(v));
      check_eq($sformatf("%s_i%0d_seq", tag, k), 64'(f_o[k].data[15:0]), 64'(seq));
    end
  endtask

  task automatic expect_rdy_all(input string tag, input logic r);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_i%0d", tag, k), 64'(rdy_o[k]), 64'(r));
    end
  endtask

  typedef struct {
    logic [7:0] cid;
    logic [1:0] sx, sy, hx, hy;
  } vec_t;

  initial begin
    vec_t vt [3];
    vt[0] = '{cid: 8'd5,   sx: 2'd1, sy: 2'd0, hx: 2'd0, hy: 2'd0};
    vt[1] = '{cid: 8'd7,   sx: 2'd0, sy: 2'd0, hx: 2'd0, hy: 2'd1};
    vt[2] = '{cid: 8'hB5,  sx: 2'd1, sy: 2'd0, hx: 2'd1, hy: 2'd0};

    // Reset state
    tick();
    tick();
    for (int k = 0; k < 3; k++) check_eq($sformatf("rst_v_i%0d", k), 64'(v_o[k]), 64'd0);
    check_eq("rst_perf", perf_sl, 64'd0);
    rst = 1'b0;
    #1;
    expect_rdy_all("rst_rdy", 1'b1);

    // Test 1: single flit, one-cycle latency
    drive(1'b1, 8'd3, 16'd1);
    tick();
    expect_all("t1", 8'd3, 16'd1, 2'd1, 2'd1, 2'd1, 2'd1);
    drive(1'b0, 8'd0, 16'd0);
    tick();
    expect_seq_all("t1_empty_hold", 1'b0, 16'd1);

    // Test 2: stalled output, third flit back-pressured, order preserved
    out_rdy = 1'b0;
    drive(1'b1, 8'd0, 16'd2);
    tick();
    expect_all("t2_f1", 8'd0, 16'd2, 2'd0, 2'd0, 2'd0, 2'd0);
    expect_rdy_all("t2_rdy1", 1'b1);
    drive(1'b1, 8'd1, 16'd3);
    tick();
    expect_rdy_all("t2_rdy_full", 1'b0);
    expect_seq_all("t2_stall_a", 1'b1, 16'd2);
    drive(1'b1, 8'd2, 16'd4);
    tick();
    expect_rdy_all("t2_bp3", 1'b0);
    tick();
    expect_seq_all("t2_stall_b", 1'b1, 16'd2);
    out_rdy = 1'b1;
    tick();
    expect_all("t2_f2", 8'd1, 16'd3, 2'd1, 2'd0, 2'd1, 2'd0);
    expect_rdy_all("t2_rdy_back", 1'b1);
    tick();
    expect_all("t2_f3", 8'd2, 16'd4, 2'd0, 2'd1, 2'd0, 2'd1);
    drive(1'b0, 8'd0, 16'd0);
    tick();
    expect_seq_all("t2_drained", 1'b0, 16'd4);

    // Test 3: remap write same cycle as accept uses old entry; next flit uses new one
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_slice = 2'd0;
    drive(1'b1, 8'd3, 16'd5);
    tick();
    cfg_we = 1'b0;
    expect_all("t3_old", 8'd3, 16'd5, 2'd1, 2'd1, 2'd1, 2'd1);
    drive(1'b1, 8'd3, 16'd6);
    tick();
    expect_all("t3_new", 8'd3, 16'd6, 2'd0, 2'd0, 2'd0, 2'd0);

    // Test 4: more cids, back to back (central ignores cid and remap)
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vt[i].cid, 16'(7 + i));
      tick();
      expect_all($sformatf("t4_v%0d", i), vt[i].cid, 16'(7 + i),
                 vt[i].sx, vt[i].sy, vt[i].hx, vt[i].hy);
    end
    drive(1'b0, 8'd0, 16'd0);
    tick();

    // Test 6: reset with two flits buffered drops them and restores identity map
    out_rdy = 1'b0;
    drive(1'b1, 8'd0, 16'd10);
    tick();
    drive(1'b1, 8'd1, 16'd11);
    tick();
    drive(1'b0, 8'd0, 16'd0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check_eq($sformatf("t6_rst_v_i%0d", k), 64'(v_o[k]), 64'd0);
    rst = 1'b0;
    out_rdy = 1'b1;
    #1;
    expect_rdy_all("t6_rdy", 1'b1);
    drive(1'b1, 8'd3, 16'd12);
    tick();
    expect_all("t6_ident", 8'd3, 16'd12, 2'd1, 2'd1, 2'd1, 2'd1);
    drive(1'b0, 8'd0, 16'd0);
    tick();
    expect_seq_all("t6_empty", 1'b0, 16'd12);

`ifdef HN_SAM_PERF_CNT_EN
    // Test 5: counters saturate, clear wins over a coincident transfer
    check_eq("t5_cnt3", 64'(perf_sl[3*16 +: 16]), 64'(16'd1));
    drive(1'b1, 8'd2, 16'd20);
    repeat (70000) @(posedge clk);
    #1;
    check_eq("t5_sat", 64'(perf_sl[2*16 +: 16]), 64'(16'hFFFF));
    perf_clr = 1'b1;
    tick();
    check_eq("t5_clr", 64'(perf_sl[2*16 +: 16]), 64'(16'h0000));
    perf_clr = 1'b0;
    drive(1'b0, 8'd0, 16'd0);
    tick();
    check_eq("t5_after_clr", 64'(perf_sl[2*16 +: 16]), 64'(16'd1));
`else
    // Counters compiled out: outputs stay zero and clear is ignored
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check_eq("t5_off_sl", perf_sl, 64'd0);
    check_eq("t5_off_ce", perf_ce, 64'd0);
    check_eq("t5_off_ha", perf_ha, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
